// File: rtl/nios_nios2_gen2_0_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug OCI memory controller:
// FSM state encoding, jdo field positions and the sticky-error update rule.
package nios_nios2_gen2_0_cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_CAPT  = 2'd2,
    ST_WR_ISSUE = 2'd3
  } ocimem_state_e;

  localparam int JDO_RW      = 35;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_ADDR_LO = 17;

  // A set request always overrides a clear arriving in the same cycle.
  function automatic logic err_next(input logic cur, input logic set, input logic clr);
    logic nxt;
    if (set) begin
      nxt = 1'b1;
    end else if (clr) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nios_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Sysclk-side OCI memory controller: decodes jdo commands into single-word
// debug RAM reads/writes with an auto-incrementing word address.
module nios_nios2_gen2_0_cpu_debug_ocimem_ctrl
  import nios_nios2_gen2_0_cpu_debug_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  input  logic          debugack,
  input  logic [31:0]   ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  ocimem_state_e r_state;
  logic [AW-1:0] r_mon_areg;
  logic [AW-1:0] r_ram_addr;
  logic [31:0]   r_ram_wdata;
  logic          r_ram_we;
  logic          r_ram_re;
  logic [31:0]   r_mon_dreg;
  logic          r_ready;
  logic          r_error;
  logic          r_cmd_b;

  logic          w_busy;
  logic          w_any_cmd;
  logic          w_data_cmd;
  logic          w_go;
  logic          w_go_wr;
  logic          w_go_rd;
  logic          w_err_set;
  logic [AW-1:0] w_jdo_addr;
  logic [31:0]   w_jdo_data;
  logic          w_unused;

  assign w_jdo_addr = jdo[JDO_ADDR_LO +: AW];
  assign w_jdo_data = jdo[JDO_DATA_HI:JDO_DATA_LO];
  assign w_unused   = ^{jdo[37:36], jdo[2:0]};

  // Command qualification: _a has priority over _b, data access needs debugack.
  always_comb begin
    w_busy     = (r_state != ST_IDLE);
    w_any_cmd  = take_action_ocimem_a | take_action_ocimem_b;
    if (take_action_ocimem_a) begin
      w_data_cmd = jdo[JDO_RW];
    end else begin
      w_data_cmd = take_action_ocimem_b;
    end
    w_go      = !w_busy && w_data_cmd && debugack;
    w_go_wr   = w_go && !take_action_ocimem_a && jdo[JDO_RW];
    w_go_rd   = w_go && !w_go_wr;
    w_err_set = (w_busy && w_any_cmd)
              || (!w_busy && w_data_cmd && !debugack)
              || (!w_busy && take_action_ocimem_a && take_action_ocimem_b);
  end

  // Access FSM with address counter and registered RAM/monitor outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_mon_areg  <= {AW{1'b0}};
      r_ram_addr  <= {AW{1'b0}};
      r_ram_wdata <= 32'd0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      r_mon_dreg  <= 32'd0;
      r_ready     <= 1'b1;
      r_cmd_b     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ram_we <= 1'b0;
          r_ram_re <= 1'b0;
          if (take_action_ocimem_a) begin
            r_mon_areg <= w_jdo_addr;
          end
          if (w_go_wr) begin
            r_state     <= ST_WR_ISSUE;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_mon_areg;
            r_ram_wdata <= w_jdo_data;
            r_ready     <= 1'b0;
            r_cmd_b     <= 1'b1;
          end else if (w_go_rd) begin
            r_state    <= ST_RD_ISSUE;
            r_ram_re   <= 1'b1;
            r_ram_addr <= take_action_ocimem_a ? w_jdo_addr : r_mon_areg;
            r_ready    <= 1'b0;
            r_cmd_b    <= !take_action_ocimem_a;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          r_ram_re <= 1'b0;
          r_state  <= ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          r_mon_dreg <= ram_rdata;
          if (r_cmd_b) begin
            r_mon_areg <= r_mon_areg + ADDR_ONE;
          end
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        ST_WR_ISSUE: begin
          r_ram_we   <= 1'b0;
          r_mon_dreg <= r_ram_wdata;
          r_mon_areg <= r_mon_areg + ADDR_ONE;
          r_state    <= ST_IDLE;
          r_ready    <= 1'b1;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_ram_re <= 1'b0;
          r_state  <= ST_IDLE;
          r_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_error <= 1'b0;
    end else begin
      r_error <= err_next(r_error, w_err_set, take_no_action_ocimem_a);
    end
  end

  assign ram_addr      = r_ram_addr;
  assign ram_wdata     = r_ram_wdata;
  assign ram_we        = r_ram_we;
  assign ram_re        = r_ram_re;
  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

endmodule

// File: tb/tb_nios_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Scoreboard bench: stimulus pushes expected RAM strobes and MonDReg results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_nios_nios2_gen2_0_cpu_debug_ocimem_ctrl;

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } ram_ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = 38'd0;
  logic        ta_a = 1'b0;
  logic        ta_b = 1'b0;
  logic        tna_a = 1'b0;
  logic        debugack = 1'b0;
  logic [31:0] ram_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] mon_dreg;
  logic        mon_ready;
  logic        mon_error;

  int checks = 0;
  int errors = 0;
  ram_ev_t     ev_q[$];
  logic [31:0] dreg_q[$];
  logic [31:0] mem [256];
  logic        prev_ready = 1'b1;

  nios_nios2_gen2_0_cpu_debug_ocimem_ctrl #(.AW(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .debugack                (debugack),
    .ram_rdata               (ram_rdata),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_error)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    ram_rdata = 32'd0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every RAM strobe and every ready rising edge consumes one expectation.
  always @(negedge clk) begin
    ram_ev_t e;
    logic [31:0] d;
    if (reset_n) begin
      if (ram_we || ram_re) begin
        checks++;
        if (ram_we && ram_re) begin
          errors++;
          $display("FAIL both_strobes: we=%0b re=%0b expected one", ram_we, ram_re);
        end else if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_strobe: we=%0b re=%0b addr=%02h expected none", ram_we, ram_re, ram_addr);
        end else begin
          e = ev_q.pop_front();
          if (ram_we !== e.is_wr || ram_addr !== e.addr || (e.is_wr && ram_wdata !== e.data)) begin
            errors++;
            $display("FAIL ram_access: we=%0b addr=%02h wdata=%08h expected we=%0b addr=%02h wdata=%08h",
                     ram_we, ram_addr, ram_wdata, e.is_wr, e.addr, e.data);
          end
        end
      end
      if (mon_ready && !prev_ready) begin
        checks++;
        if (dreg_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: MonDReg=%08h expected no completion", mon_dreg);
        end else begin
          d = dreg_q.pop_front();
          if (mon_dreg !== d) begin
            errors++;
            $display("FAIL mondreg: got %08h expected %08h", mon_dreg, d);
          end
        end
      end
    end
    prev_ready = mon_ready;
  end

  function automatic logic [37:0] jdo_a(input logic rw, input logic [7:0] addr);
    logic [37:0] j;
    j = 38'd0;
    j[35] = rw;
    j[24:17] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic rw, input logic [31:0] data);
    logic [37:0] j;
    j = 38'd0;
    j[35] = rw;
    j[34:3] = data;
    return j;
  endfunction

  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
    @(negedge clk);
    ta_a = a; ta_b = b; tna_a = na; jdo = j;
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_wr(input logic [7:0] addr, input logic [31:0] data);
    ram_ev_t e;
    e.is_wr = 1'b1; e.addr = addr; e.data = data;
    ev_q.push_back(e);
    dreg_q.push_back(data);
  endtask

  task automatic exp_rd(input logic [7:0] addr, input logic [31:0] data, input logic done);
    ram_ev_t e;
    e.is_wr = 1'b0; e.addr = addr; e.data = 32'd0;
    ev_q.push_back(e);
    if (done) dreg_q.push_back(data);
  endtask

  initial begin
    idle(3);
    check("rst_mondreg", mon_dreg, 32'd0);
    check("rst_ready", {31'd0, mon_ready}, 32'd1);
    check("rst_error", {31'd0, mon_error}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    check("rel_addr", {24'd0, ram_addr}, 32'd0);
    check("rel_wdata", ram_wdata, 32'd0);
    check("rel_we", {31'd0, ram_we}, 32'd0);
    check("rel_re", {31'd0, ram_re}, 32'd0);
    idle(10);

    // Address load then two writes, then a read to show the address reached 0x12.
    debugack = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h10)); idle(3);
    exp_wr(8'h10, 32'hDEADBEEF); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b1, 32'hDEADBEEF)); idle(3);
    exp_wr(8'h11, 32'h12345678); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b1, 32'h12345678)); idle(3);
    exp_rd(8'h12, 32'h0, 1'b1); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b0, 32'h0)); idle(4);

    // Load-with-read: no increment, so the next _b reads the same word.
    exp_rd(8'h10, 32'hDEADBEEF, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h10));
    check("rd_ready_low", {31'd0, mon_ready}, 32'd0);
    idle(2);
    check("rd_t3_mondreg", mon_dreg, 32'hDEADBEEF);
    check("rd_t3_ready", {31'd0, mon_ready}, 32'd1);
    idle(2);
    exp_rd(8'h10, 32'hDEADBEEF, 1'b1); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b0, 32'h0)); idle(4);
    exp_rd(8'h11, 32'h12345678, 1'b1); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b0, 32'h0)); idle(4);

    // Wrap-around.
    pulse(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'hFF)); idle(3);
    exp_wr(8'hFF, 32'hA5A5A5A5); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b1, 32'hA5A5A5A5)); idle(3);
    exp_rd(8'h00, 32'h0, 1'b1); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b0, 32'h0)); idle(4);

    // No debugack: no strobe, no increment, sticky error.
    debugack = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b1, 32'h11112222));
    check("noack_error", {31'd0, mon_error}, 32'd1);
    idle(3);
    debugack = 1'b1;
    exp_wr(8'h01, 32'h33334444); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b1, 32'h33334444)); idle(3);
    check("error_sticky", {31'd0, mon_error}, 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 38'd0);
    check("error_cleared", {31'd0, mon_error}, 32'd0);
    idle(2);

    // _b one cycle after a load-with-read is ignored and flags an error.
    exp_rd(8'h10, 32'hDEADBEEF, 1'b1);
    @(negedge clk); ta_a = 1'b1; jdo = jdo_a(1'b1, 8'h10);
    @(negedge clk); ta_a = 1'b0; ta_b = 1'b1; jdo = jdo_b(1'b1, 32'hCAFECAFE);
    @(negedge clk); ta_b = 1'b0;
    check("busy_error", {31'd0, mon_error}, 32'd1);
    idle(3);
    exp_rd(8'h10, 32'hDEADBEEF, 1'b1); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b0, 32'h0)); idle(4);
    pulse(1'b0, 1'b0, 1'b1, 38'd0); idle(2);

    // _a and _b together: _a wins, error set.
    pulse(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 8'h20));
    check("both_error", {31'd0, mon_error}, 32'd1);
    idle(2);
    exp_wr(8'h20, 32'h55AA55AA); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b1, 32'h55AA55AA)); idle(3);

    // Reset during RD_CAPT aborts the read.
    exp_rd(8'h11, 32'h0, 1'b0);
    @(negedge clk); ta_a = 1'b1; jdo = jdo_a(1'b1, 8'h11);
    @(negedge clk); ta_a = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("abort_mondreg", mon_dreg, 32'd0);
    check("abort_ready", {31'd0, mon_ready}, 32'd1);
    check("abort_error", {31'd0, mon_error}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(10);
    exp_wr(8'h00, 32'h0BADF00D); pulse(1'b0, 1'b1, 1'b0, jdo_b(1'b1, 32'h0BADF00D)); idle(3);
    check("abort_mem11", mem[8'h11], 32'h12345678);

    idle(3);
    check("ev_q_empty", ev_q.size(), 32'd0);
    check("dreg_q_empty", dreg_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
